// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer: loads 16 message words, steps the round datapath, strobes the final hash add.
// Latency: start at cycle 0 -> done at WORDS+3+ROUNDS*ROUND_CYCLES (147 with defaults), back-to-back words.
// Backpressure: w_ready is high throughout LOAD; a low w_valid stalls the load indefinitely.
module sha256_round_ctrl #(
  parameter int ROUNDS       = 64,
  parameter int ROUND_CYCLES = 2,
  parameter int WORDS        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       w_valid,
  output logic       w_ready,
  output logic       w_load,
  output logic [3:0] w_idx,
  output logic       init_state,
  output logic       round_en,
  output logic [5:0] round_idx,
  output logic       w_sel,
  output logic       final_add,
  output logic       busy,
  output logic       done
);

  // Phase counter needs at least one bit even when a round is a single clock.
  localparam int PW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

  localparam logic [3:0]    W_LAST = 4'(WORDS - 1);
  localparam logic [5:0]    R_LAST = 6'(ROUNDS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(ROUND_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    w_idx_q, w_idx_nxt;
  logic [5:0]    round_idx_q, round_idx_nxt;
  logic [PW-1:0] phase_q, phase_nxt;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      w_idx_q     <= '0;
      round_idx_q <= '0;
      phase_q     <= '0;
    end else begin
      state       <= state_nxt;
      w_idx_q     <= w_idx_nxt;
      round_idx_q <= round_idx_nxt;
      phase_q     <= phase_nxt;
    end
  end

  // Next-state logic and output decode; every strobe except w_load comes from registered state.
  always_comb begin
    state_nxt     = state;
    w_idx_nxt     = w_idx_q;
    round_idx_nxt = round_idx_q;
    phase_nxt     = phase_q;

    w_ready    = (state == S_LOAD);
    w_load     = (state == S_LOAD) && w_valid;
    init_state = (state == S_INIT);
    round_en   = (state == S_ROUND) && (phase_q == P_LAST);
    w_sel      = (state == S_ROUND) && (round_idx_q >= 6'd16);
    final_add  = (state == S_FINAL);
    done       = (state == S_DONE);
    busy       = (state != S_IDLE);

    if (abort && state != S_IDLE) begin
      // Cancel wins over everything except reset; strobes above still reflect the aborted state.
      state_nxt     = S_IDLE;
      w_idx_nxt     = '0;
      round_idx_nxt = '0;
      phase_nxt     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_LOAD;
            w_idx_nxt = '0;
          end
        end
        S_LOAD: begin
          if (w_valid) begin
            if (w_idx_q == W_LAST) begin
              state_nxt = S_INIT;
              w_idx_nxt = '0;
            end else begin
              w_idx_nxt = w_idx_q + 4'd1;
            end
          end
        end
        S_INIT: begin
          state_nxt     = S_ROUND;
          round_idx_nxt = '0;
          phase_nxt     = '0;
        end
        S_ROUND: begin
          if (phase_q == P_LAST) begin
            phase_nxt = '0;
            // The last round leaves round_idx parked at ROUNDS-1.
            if (round_idx_q == R_LAST) state_nxt = S_FINAL;
            else                       round_idx_nxt = round_idx_q + 6'd1;
          end else begin
            phase_nxt = phase_q + PW'(1);
          end
        end
        S_FINAL: state_nxt = S_DONE;
        S_DONE: begin
          state_nxt     = S_IDLE;
          w_idx_nxt     = '0;
          round_idx_nxt = '0;
          phase_nxt     = '0;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_idx     = w_idx_q;
  assign round_idx = round_idx_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: instance 0 uses default timing, instance 1 a single-cycle round.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Each block run is bounded by a cycle limit so a stuck FSM still reaches the summary line.
module tb_sha256_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [2];
  logic       abort [2];
  logic       w_valid [2];
  logic       w_ready [2];
  logic       w_load [2];
  logic [3:0] w_idx [2];
  logic       init_state [2];
  logic       round_en [2];
  logic [5:0] round_idx [2];
  logic       w_sel [2];
  logic       final_add [2];
  logic       busy [2];
  logic       done [2];

  sha256_round_ctrl #(.ROUNDS(64), .ROUND_CYCLES(2), .WORDS(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .w_valid(w_valid[0]),
    .w_ready(w_ready[0]), .w_load(w_load[0]), .w_idx(w_idx[0]), .init_state(init_state[0]),
    .round_en(round_en[0]), .round_idx(round_idx[0]), .w_sel(w_sel[0]),
    .final_add(final_add[0]), .busy(busy[0]), .done(done[0])
  );

  sha256_round_ctrl #(.ROUNDS(64), .ROUND_CYCLES(1), .WORDS(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .w_valid(w_valid[1]),
    .w_ready(w_ready[1]), .w_load(w_load[1]), .w_idx(w_idx[1]), .init_state(init_state[1]),
    .round_en(round_en[1]), .round_idx(round_idx[1]), .w_sel(w_sel[1]),
    .final_add(final_add[1]), .busy(busy[1]), .done(done[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] out_vec(input int d);
    return {w_ready[d], w_load[d], w_idx[d], init_state[d], round_en[d], round_idx[d],
            w_sel[d], final_add[d], busy[d], done[d]};
  endfunction

  typedef struct {
    int load_cnt, load_err, first_load, last_load, stall_seen, stall_err;
    int init_cnt, init_cyc, re_cnt, re_first, re_last, space_err, idx_err, wsel_err;
    int final_cnt, final_cyc, done_cnt, done_cyc, busy_abort, busy1, busy2;
  } rec_t;

  rec_t r;

  // Runs one block on instance d with start in relative cycle 0 and logs every strobe.
  task automatic run_block(input int d, input int rc, input int stall_len, input int abort_k,
                           input int xs1, input int xs2, input int limit);
    int stall_cnt;
    stall_cnt = 0;
    r = '{load_cnt:0, load_err:0, first_load:-1, last_load:-1, stall_seen:0, stall_err:0,
          init_cnt:0, init_cyc:-1, re_cnt:0, re_first:-1, re_last:-1, space_err:0, idx_err:0,
          wsel_err:0, final_cnt:0, final_cyc:-1, done_cnt:0, done_cyc:-1, busy_abort:-1,
          busy1:-1, busy2:-1};
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      start[d] = (k == 0) || (k == xs1) || (k == xs2);
      abort[d] = (k == abort_k);
      if (stall_len > 0 && r.load_cnt == 8 && stall_cnt < stall_len) begin
        w_valid[d] = 1'b0;
        stall_cnt++;
      end else begin
        w_valid[d] = 1'b1;
      end
      @(negedge clk);
      if (w_load[d]) begin
        if (int'(w_idx[d]) != r.load_cnt) r.load_err++;
        if (r.load_cnt == 0) r.first_load = k;
        r.last_load = k;
        r.load_cnt++;
      end
      if (!w_valid[d] && busy[d]) begin
        r.stall_seen++;
        if (!w_ready[d] || w_idx[d] != 4'd8) r.stall_err++;
      end
      if (init_state[d]) begin
        r.init_cnt++;
        r.init_cyc = k;
      end
      if (round_en[d]) begin
        if (int'(round_idx[d]) != r.re_cnt) r.idx_err++;
        if (w_sel[d] != (r.re_cnt >= 16)) r.wsel_err++;
        if (r.re_cnt == 0) r.re_first = k;
        else if (k - r.re_last != rc) r.space_err++;
        r.re_last = k;
        r.re_cnt++;
      end
      if ((init_state[d] || final_add[d] || done[d] || w_ready[d]) && w_sel[d]) r.wsel_err++;
      if (final_add[d]) begin
        r.final_cnt++;
        r.final_cyc = k;
      end
      if (done[d]) begin
        r.done_cnt++;
        r.done_cyc = k;
      end
      if (k == abort_k + 1) r.busy_abort = int'(busy[d]);
      if (r.done_cnt > 0 && k == r.done_cyc + 1) r.busy1 = int'(busy[d]);
      if (r.done_cnt > 0 && k == r.done_cyc + 2) begin
        r.busy2 = int'(busy[d]);
        break;
      end
    end
    start[d]   = 1'b0;
    abort[d]   = 1'b0;
    w_valid[d] = 1'b0;
  endtask

  task automatic check_clean(input string tag, input int done_at, input int re_first,
                             input int re_last, input int final_at, input int last_load);
    check({tag, "_loads"},     r.load_cnt, 16);
    check({tag, "_load_idx"},  r.load_err, 0);
    check({tag, "_first_ld"},  r.first_load, 1);
    check({tag, "_last_ld"},   r.last_load, last_load);
    check({tag, "_init_cnt"},  r.init_cnt, 1);
    check({tag, "_init_cyc"},  r.init_cyc, last_load + 1);
    check({tag, "_re_cnt"},    r.re_cnt, 64);
    check({tag, "_re_first"},  r.re_first, re_first);
    check({tag, "_re_last"},   r.re_last, re_last);
    check({tag, "_re_space"},  r.space_err, 0);
    check({tag, "_round_idx"}, r.idx_err, 0);
    check({tag, "_w_sel"},     r.wsel_err, 0);
    check({tag, "_final_cnt"}, r.final_cnt, 1);
    check({tag, "_final_cyc"}, r.final_cyc, final_at);
    check({tag, "_done_cnt"},  r.done_cnt, 1);
    check({tag, "_done_cyc"},  r.done_cyc, done_at);
    check({tag, "_idle_after"}, r.busy1, 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d]   = 1'b1;
      abort[d]   = 1'b0;
      w_valid[d] = 1'b0;
    end

    // Reset held three cycles with start high: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_outs0", out_vec(0), 0);
      check("rst_outs1", out_vec(1), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_still_idle", busy[0], 0);
    @(posedge clk); #1;
    start[0] = 1'b0; start[1] = 1'b0;
    abort[0] = 1'b1; abort[1] = 1'b1;
    @(negedge clk);
    check("rel_load_rdy", w_ready[0], 1);
    check("rel_load_busy1", busy[1], 1);
    @(posedge clk); #1;
    abort[0] = 1'b0; abort[1] = 1'b0;
    @(negedge clk);
    check("abort_load_idle0", busy[0], 0);
    check("abort_load_idle1", busy[1], 0);

    // Nominal block, words back to back.
    run_block(0, 2, 0, -1, -1, -1, 300);
    check_clean("nom", 147, 19, 145, 146, 16);

    // Five-cycle w_valid stall after word 7.
    run_block(0, 2, 5, -1, -1, -1, 300);
    check("stall_seen", r.stall_seen, 5);
    check("stall_hold", r.stall_err, 0);
    check("stall_last_ld", r.last_load, 21);
    check("stall_done", r.done_cyc, 152);
    check("stall_re_cnt", r.re_cnt, 64);

    // Abort in round 30 (cycles 78..79), then a clean block.
    run_block(0, 2, 0, 78, -1, -1, 120);
    check("abort_idle", r.busy_abort, 0);
    check("abort_re_cnt", r.re_cnt, 30);
    check("abort_final", r.final_cnt, 0);
    check("abort_done", r.done_cnt, 0);
    run_block(0, 2, 0, -1, -1, -1, 300);
    check_clean("post_abort", 147, 19, 145, 146, 16);

    // Start pulses during ROUND and during DONE are ignored and not queued.
    run_block(0, 2, 0, -1, 50, 147, 300);
    check_clean("ign_start", 147, 19, 145, 146, 16);
    check("ign_start_idle2", r.busy2, 0);

    // Single-cycle rounds.
    run_block(1, 1, 0, -1, -1, -1, 300);
    check_clean("rc1", 83, 18, 81, 82, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
